// File: rtl/read_adt7320_pkg.sv
// Shared types and constants for the ADT7320 three-sensor reader.
// Optional SPI-reset preamble: READ_ADT7320_SPI_RESET_EN.
package read_adt7320_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPIRST,
    SETUP,
    SCLK_LO,
    SCLK_HI,
    HOLD
  } state_t;

  localparam logic       CMD_WR_N = 1'b0;
  localparam logic       CMD_RD   = 1'b1;
  localparam logic [2:0] CMD_TAIL = 3'b000;

  localparam logic [5:0] CMD_BITS  = 6'd8;
  localparam logic [5:0] DATA_BITS = 6'd16;
  localparam logic [5:0] RD_BITS   = CMD_BITS + DATA_BITS;
  localparam logic [5:0] RST_BITS  = 6'd32;

  function automatic logic [7:0] rd_cmd(input logic [2:0] a);
    return {CMD_WR_N, CMD_RD, a, CMD_TAIL};
  endfunction

endpackage

// File: rtl/adt7320_spi_xfer.sv
// One CS-framed SPI mode-3 transfer: setup, N sclk periods, hold.
// rstframe selects the all-ones 32-period reset frame.
module adt7320_spi_xfer
  import read_adt7320_pkg::*;
#(
  parameter int CLKDIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rstframe,
  input  logic [2:0]  csval,
  input  logic [7:0]  cmd,
  input  logic        dout,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx,
  output logic [2:0]  cs,
  output logic        sclk,
  output logic        din
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLKDIV - 1);

  state_t      state, nxt;
  logic [CW-1:0] cnt;
  logic [5:0]  bitn;
  logic [5:0]  nbits;
  logic [31:0] tx;
  logic [15:0] rxsr;
  logic        rmode;
  logic        tick;

  assign tick = (cnt == CMAX);
  assign busy = (state != IDLE);
  assign done = (state == HOLD) && tick && !rmode;
  assign rx   = rxsr;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = rstframe ? SPIRST : SETUP;
      SPIRST,
      SETUP:   if (tick) nxt = SCLK_LO;
      SCLK_LO: if (tick) nxt = SCLK_HI;
      SCLK_HI: if (tick) nxt = (bitn == nbits) ? HOLD : SCLK_LO;
      HOLD:    if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt   <= '0;
      bitn  <= '0;
      nbits <= '0;
      tx    <= '0;
      rxsr  <= '0;
      rmode <= 1'b0;
      cs    <= 3'b111;
      sclk  <= 1'b1;
      din   <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == IDLE && start) begin
        cs    <= csval;
        tx    <= rstframe ? '1 : {cmd, 24'h0};
        nbits <= rstframe ? RST_BITS : RD_BITS;
        rmode <= rstframe;
        bitn  <= '0;
      end
      // din moves on the falling sclk edge, MSB first
      if (nxt == SCLK_LO && state != SCLK_LO) begin
        sclk <= 1'b0;
        din  <= tx[31];
        tx   <= {tx[30:0], 1'b0};
      end
      if (state == SCLK_LO && tick) begin
        sclk <= 1'b1;
        rxsr <= {rxsr[14:0], dout};
        bitn <= bitn + 6'd1;
      end
      if (state == SCLK_HI && tick && nxt == HOLD)
        din <= 1'b0;
      if (state == HOLD && tick)
        cs <= 3'b111;
    end

endmodule

// File: rtl/read_adt7320.sv
// Round-robin reader for three ADT7320 sensors on a shared SPI bus.
// Define READ_ADT7320_SPI_RESET_EN for a bus-reset frame after reset.
module read_adt7320
  import read_adt7320_pkg::*;
#(
  parameter int CLKDIV     = 10,
  parameter int GAP_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  addr,
  output logic [15:0] result0,
  output logic [15:0] result1,
  output logic [15:0] result2,
  output logic [2:0]  cs,
  output logic        sclk,
  output logic        din,
  input  logic        dout
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [GW-1:0] gap;
  logic [1:0]    sel;
  logic          busy;
  logic          done;
  logic          start;
  logic          pend;
  logic [2:0]    csval;
  logic [15:0]   rx;

  assign start = !busy && (gap == GW'(GAP_CYCLES - 1));
  assign csval = pend ? 3'b000 : ~(3'b001 << sel);

`ifdef READ_ADT7320_SPI_RESET_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset)     pend <= 1'b1;
    else if (start) pend <= 1'b0;
`else
  assign pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gap     <= '0;
      sel     <= '0;
      result0 <= '0;
      result1 <= '0;
      result2 <= '0;
    end else begin
      gap <= (busy || start) ? '0 : gap + 1'b1;
      if (done) begin
        sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        unique case (1'b1)
          sel == 2'd0: result0 <= rx;
          sel == 2'd1: result1 <= rx;
          default:     result2 <= rx;
        endcase
      end
    end

  adt7320_spi_xfer #(
    .CLKDIV(CLKDIV)
  ) u_xfer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rstframe (pend),
    .csval    (csval),
    .cmd      (rd_cmd(addr)),
    .dout     (dout),
    .busy     (busy),
    .done     (done),
    .rx       (rx),
    .cs       (cs),
    .sclk     (sclk),
    .din      (din)
  );

endmodule

// File: tb/tb_read_adt7320.sv
// Bench for read_adt7320: frame-level monitor, sensor models, scoreboard.
// Also covers the READ_ADT7320_SPI_RESET_EN preamble when defined.
module tb_read_adt7320;

  localparam int CLKDIV = 10;
  localparam int GAP    = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr;
  logic [15:0] result0, result1, result2;
  logic [2:0]  cs;
  logic        sclk;
  logic        din;
  logic        dout;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  read_adt7320 #(
    .CLKDIV(CLKDIV),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .result0 (result0),
    .result1 (result1),
    .result2 (result2),
    .cs      (cs),
    .sclk    (sclk),
    .din     (din),
    .dout    (dout)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference state: expected results and sensor rotation
  logic [15:0] expr [3];
  logic [15:0] dq [$] = '{16'h0C80, 16'hABCD, 16'h0001, 16'h1234};
  int          nexts;
  int          frames = 0;
  int          rsttog = 0;
  bit          rstpend;

  // frame monitor state
  int          cyc = 0;
  bit          infr = 0;
  logic        psclk = 1'b1;
  logic [2:0]  pcs = 3'b111;
  logic [2:0]  paddr = 3'd0;
  logic [2:0]  fcs;
  logic [2:0]  eaddr;
  logic [15:0] word;
  logic [31:0] dinbits;
  int          nfall, nrise, t_cs, t_f1, t_r, pmin, pmax;
  int          gapn = 0;
  int          idlebad = 0;
  int          csbad;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (sclk !== 1'b1 || cs !== 3'b111) rsttog++;
      infr    = 0;
      nexts   = 0;
      gapn    = 0;
      idlebad = 0;
      for (int i = 0; i < 3; i++) expr[i] = 16'h0;
`ifdef READ_ADT7320_SPI_RESET_EN
      rstpend = 1;
`else
      rstpend = 0;
`endif
    end else begin
      if (!infr && cs != 3'b111) begin
        chk("gap_cycles", 32'(gapn), 32'(GAP));
        chk("idle_din", 32'(idlebad), 32'd0);
        chk("stable_r0", 32'(result0), 32'(expr[0]));
        chk("stable_r1", 32'(result1), 32'(expr[1]));
        chk("stable_r2", 32'(result2), 32'(expr[2]));
        infr    = 1;
        fcs     = cs;
        eaddr   = paddr;
        t_cs    = cyc;
        nfall   = 0;
        nrise   = 0;
        dinbits = 0;
        pmin    = 1000;
        pmax    = 0;
        csbad   = 0;
        word    = (!rstpend && dq.size() > 0) ? dq.pop_front()
                                              : 16'($urandom);
      end
      if (infr && cs != 3'b111) begin
        if (cs != fcs) csbad++;
        if (psclk && !sclk) begin
          nfall++;
          if (nfall == 1) t_f1 = cyc;
          if (nfall >= 9 && nfall <= 24) dout = word[24 - nfall];
          else dout = 1'($urandom);
        end
        if (!psclk && sclk) begin
          if (nrise > 0) begin
            if (cyc - t_r < pmin) pmin = cyc - t_r;
            if (cyc - t_r > pmax) pmax = cyc - t_r;
          end
          t_r = cyc;
          nrise++;
          dinbits = {dinbits[30:0], din};
        end
      end else if (infr) begin
        chk("cs_stable", 32'(csbad), 32'd0);
        chk("setup", 32'(t_f1 - t_cs), 32'(CLKDIV));
        chk("hold", 32'(cyc - t_r), 32'(2 * CLKDIV));
        chk("period_min", 32'(pmin), 32'(2 * CLKDIV));
        chk("period_max", 32'(pmax), 32'(2 * CLKDIV));
        if (rstpend) begin
          chk("rstframe_cs", 32'(fcs), 32'd0);
          chk("rstframe_falls", 32'(nfall), 32'd32);
          chk("rstframe_din", dinbits, 32'hFFFF_FFFF);
          rstpend = 0;
        end else begin
          chk("cs_order", 32'(fcs), 32'(3'b111 ^ (3'b001 << nexts)));
          chk("falls", 32'(nfall), 32'd24);
          chk("cmd", 32'(dinbits[23:16]), 32'({2'b01, eaddr, 3'b000}));
          chk("din_data", 32'(dinbits[15:0]), 32'd0);
          expr[nexts] = word;
          nexts = (nexts + 1) % 3;
          chk("result0", 32'(result0), 32'(expr[0]));
          chk("result1", 32'(result1), 32'(expr[1]));
          chk("result2", 32'(result2), 32'(expr[2]));
          frames++;
        end
        infr    = 0;
        gapn    = 1;
        idlebad = 0;
      end else begin
        gapn++;
        if (din !== 1'b0) idlebad++;
      end
    end
    psclk = sclk;
    pcs   = cs;
    paddr = addr;
  end

  // addr wanders once the first directed read is done
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (frames >= 1 && $urandom_range(0, 40) == 0) addr = 3'($urandom);
    end
  end

  initial begin
    int f0;
    bit hit;
    reset = 1'b0;
    addr  = 3'd2;
    dout  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'h7);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_r0", 32'(result0), 32'd0);
    chk("rst_r1", 32'(result1), 32'd0);
    chk("rst_r2", 32'(result2), 32'd0);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    chk("rst_sclk_toggles", 32'(rsttog), 32'd0);

    for (int i = 0; i < 20000 && frames < 6; i++) @(negedge clk);
    chk("frames_a", 32'(frames >= 6), 32'd1);

    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = (cs == 3'b101) && (nfall == 12);
    end
    chk("abort_point", 32'(hit), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_cs", 32'(cs), 32'h7);
    chk("abort_sclk", 32'(sclk), 32'd1);
    chk("abort_din", 32'(din), 32'd0);
    chk("abort_r0", 32'(result0), 32'd0);
    chk("abort_r1", 32'(result1), 32'd0);
    chk("abort_r2", 32'(result2), 32'd0);
    rsttog = 0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    chk("abort_sclk_toggles", 32'(rsttog), 32'd0);

    f0 = frames;
    for (int i = 0; i < 20000 && frames < f0 + 4; i++) @(negedge clk);
    chk("frames_b", 32'(frames >= f0 + 4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
